// File: rtl/envelope_vca.sv
// Voice VCA: slew-limited envelope times signed sample, rounded and saturated,
// three-stage pipeline with a voice-activity flag for the allocator.
module envelope_vca #(
  parameter int               SAMPLE_W  = 16,
  parameter int               ENV_W     = 16,
  parameter logic [ENV_W-1:0] SLEW_STEP = 16'h0100
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  input  logic [ENV_W-1:0]    envelope_in,
  input  logic                env_idle_in,
  input  logic                mute_in,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid_out,
  output logic                active_out
);

  localparam int PROD_W = SAMPLE_W + ENV_W + 1;
  localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(64'sd1 <<< (ENV_W - 1));
  localparam logic signed [PROD_W-1:0] SAT_MAX    = PROD_W'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0] SAT_MIN    = ~SAT_MAX;

  logic signed [SAMPLE_W-1:0] s1_sample_reg;
  logic                       s1_valid_reg;
  logic [ENV_W-1:0]           env_s_reg;
  logic [ENV_W-1:0]           env_s_next;
  logic signed [PROD_W-1:0]   prod_reg;
  logic signed [PROD_W-1:0]   prod_next;
  logic                       s2_valid_reg;
  logic [SAMPLE_W-1:0]        sample_out_reg;
  logic [SAMPLE_W-1:0]        sat_next;
  logic                       valid_out_reg;
  logic                       active_reg;
  logic                       active_next;

  logic [ENV_W-1:0]         target;
  logic [ENV_W:0]           target_ext;
  logic [ENV_W:0]           env_ext;
  logic [ENV_W:0]           step_ext;
  logic signed [ENV_W:0]    env_signed;
  logic signed [PROD_W-1:0] rounded;
  logic signed [PROD_W-1:0] shifted;

  // Slew limiter; the 17-bit compares keep env_s +/- step from wrapping.
  always_comb begin
    target     = mute_in ? '0 : envelope_in;
    target_ext = {1'b0, target};
    env_ext    = {1'b0, env_s_reg};
    step_ext   = {1'b0, SLEW_STEP};
    env_s_next = target;
    if (target_ext > env_ext + step_ext) begin
      env_s_next = env_s_reg + SLEW_STEP;
    end else if (target_ext + step_ext < env_ext) begin
      env_s_next = env_s_reg - SLEW_STEP;
    end
  end

  assign env_signed = {1'b0, env_s_reg};
  assign prod_next  = PROD_W'(s1_sample_reg) * PROD_W'(env_signed);

  // Round half up, then clamp into the signed sample range.
  always_comb begin
    rounded  = prod_reg + ROUND_BIAS;
    shifted  = rounded >>> ENV_W;
    sat_next = shifted[SAMPLE_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_next = SAT_MAX[SAMPLE_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_next = SAT_MIN[SAMPLE_W-1:0];
    end
  end

  assign active_next = !((env_s_reg == '0) && env_idle_in &&
                         !s1_valid_reg && !s2_valid_reg && !valid_out_reg);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_sample_reg  <= '0;
      s1_valid_reg   <= 1'b0;
      env_s_reg      <= '0;
      prod_reg       <= '0;
      s2_valid_reg   <= 1'b0;
      sample_out_reg <= '0;
      valid_out_reg  <= 1'b0;
      active_reg     <= 1'b0;
    end else begin
      s1_valid_reg <= sample_valid_in;
      if (sample_valid_in) begin
        s1_sample_reg <= sample_in;
        env_s_reg     <= env_s_next;
      end
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        prod_reg <= prod_next;
      end
      valid_out_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        sample_out_reg <= sat_next;
      end
      active_reg <= active_next;
    end
  end

  assign sample_out       = sample_out_reg;
  assign sample_valid_out = valid_out_reg;
  assign active_out       = active_reg;

endmodule
